// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_DONE   = 2'b10
   } dmemState_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational little-endian lane logic: sub-word load extraction with
// optional sign extension, store merge into the old word, and alignment check.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] storeData,
   input  logic [1:0]  byteOffset,
   input  logic [1:0]  size,
   input  logic        signExt,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord,
   output logic        misalign
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;

   always_comb begin
      loadData   = '0;
      mergedWord = oldWord;
      misalign   = 1'b0;
      byteVal    = oldWord[{byteOffset, 3'b000} +: 8];
      halfVal    = oldWord[{byteOffset[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: begin
            loadData = {{24{signExt & byteVal[7]}}, byteVal};
            mergedWord[{byteOffset, 3'b000} +: 8] = storeData[7:0];
         end
         SZ_HALF: begin
            if (byteOffset[0]) begin
               misalign = 1'b1;
            end else begin
               loadData = {{16{signExt & halfVal[15]}}, halfVal};
               mergedWord[{byteOffset[1], 4'b0000} +: 16] = storeData[15:0];
            end
         end
         default: begin
            if (byteOffset != 2'b00) begin
               misalign = 1'b1;
            end else begin
               loadData   = oldWord;
               mergedWord = storeData;
            end
         end
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with Busy/Done handshake for the MEM stage.
// Define DMEM_SUBWORD_EN for byte/half accesses via Size/SignExt and MisalignErr.
//
// state    | meaning
// S_IDLE   | waiting; request sampled on each edge
// S_ACCESS | latency countdown; access performed when counter reaches 0
// S_DONE   | Done pulse cycle; back to idle unconditionally
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
`ifdef DMEM_SUBWORD_EN
   input  logic [1:0]  Size,
   input  logic        SignExt,
`endif
   output logic [31:0] ReadData,
   output logic        Busy,
   output logic        Done,
   output logic        MisalignErr
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   dmemState_t        state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic              capture, accessNow;
   logic [ADDR_W-1:0] capIdx;
   logic [31:0]       capData;
   logic              capRead, capWrite;
   logic [31:0]       oldWord, loadWord, newWord;
   logic              misalignNow, memWe;
   logic              unusedAddr;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      capture   = 1'b0;
      accessNow = 1'b0;
      case (state)
         S_IDLE: begin
            if (MemRead | MemWrite) begin
               stateNext = S_ACCESS;
               cntNext   = CNT_W'(LATENCY - 1);
               capture   = 1'b1;
            end
         end
         S_ACCESS: begin
            if (cnt != '0) begin
               cntNext = cnt - CNT_W'(1);
            end else begin
               accessNow = 1'b1;
               stateNext = S_DONE;
            end
         end
         S_DONE:  stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   assign oldWord = mem[capIdx];

`ifdef DMEM_SUBWORD_EN
   logic [1:0] capOffset;
   logic [1:0] capSize;
   logic       capSignExt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         capOffset  <= '0;
         capSize    <= SZ_WORD;
         capSignExt <= 1'b0;
      end else if (capture) begin
         capOffset  <= Address[1:0];
         capSize    <= Size;
         capSignExt <= SignExt;
      end
   end

   dmem_lane_align uLaneAlign (
      .oldWord    (oldWord),
      .storeData  (capData),
      .byteOffset (capOffset),
      .size       (capSize),
      .signExt    (capSignExt),
      .loadData   (loadWord),
      .mergedWord (newWord),
      .misalign   (misalignNow)
   );

   assign unusedAddr = &{1'b0, Address[31:ADDR_W+2]};
`else
   assign loadWord    = oldWord;
   assign newWord     = capData;
   assign misalignNow = 1'b0;
   assign unusedAddr  = &{1'b0, Address[31:ADDR_W+2], Address[1:0]};
`endif

   // Reset in the access cycle must suppress the write of an aborted request.
   assign memWe = accessNow & capWrite & ~misalignNow & ~Reset;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         ReadData    <= '0;
         MisalignErr <= 1'b0;
         capIdx      <= '0;
         capData     <= '0;
         capRead     <= 1'b0;
         capWrite    <= 1'b0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         Done        <= accessNow;
         MisalignErr <= accessNow & misalignNow;
         if (capture) begin
            Busy     <= 1'b1;
            capIdx   <= Address[ADDR_W+1:2];
            capData  <= WriteData;
            capRead  <= MemRead;
            capWrite <= MemWrite;
         end else if (accessNow) begin
            Busy <= 1'b0;
         end
         if (accessNow) begin
            if (misalignNow) begin
               ReadData <= '0;
            end else if (capRead) begin
               ReadData <= loadWord;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (memWe) begin
         mem[capIdx] <= newWord;
      end
   end

endmodule
